stream_serializer: RTL
======================

Name: stream_serializer

Overview:
- Parallel-in, serial-out converter. It is the transmit-side counterpart of the enable-driven serial-in delay line used in the DWT datapath.
- Accepts one vector of Depth words per handshake and emits the words one per handshake on a narrow stream.
- Slice Depth-1 goes out first. A serial-in shift chain fed by this block therefore rebuilds the original vector with the same slice ordering.
- Sits between the column/row buffers and the per-sample lifting stages.

Parameters:
- Width, 16, bits per word.
- Depth, 4, words per input vector; legal range 1..256.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- s_valid_i  input  1  input vector valid.
- s_ready_o  output  1  block can accept a vector this cycle.
- s_data_i  input  Width*Depth  vector; slice k = s_data_i[k*Width +: Width].
- s_last_i  input  1  vector is the last of a line.
- m_valid_o  output  1  output word valid.
- m_ready_i  input  1  downstream accepts word.
- m_data_o  output  Width  current word.
- m_last_o  output  1  final word of a vector whose s_last_i was 1.

Behaviour:
- Interface: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values:
  - state = IDLE, cnt = 0.
  - m_valid_o = 0, m_last_o = 0, m_data_o = 0.
  - s_ready_o = 1 once reset is released.
- Storage:
  - hold register vec [Width*Depth-1:0], last flag lst.
  - counter cnt, width max(1, $clog2(Depth)).
- States:
  - IDLE: no word held.
  - SHIFT: word pending on m_*.
- Handshakes:
  - Input transfer: s_valid_i & s_ready_o. Output transfer: m_valid_o & m_ready_i.
  - Standard valid/ready: once asserted, m_valid_o and m_data_o stay stable until the transfer.
- IDLE:
  - s_ready_o = 1, m_valid_o = 0.
  - On input transfer: load vec = s_data_i, lst = s_last_i, cnt = Depth-1; go to SHIFT.
- SHIFT:
  - m_valid_o = 1.
  - m_data_o = vec slice cnt (registered output, stable while stalled).
  - m_last_o = lst & (cnt == 0).
  - On an output transfer with cnt != 0: cnt decrements by 1.
- s_ready_o:
  - s_ready_o = (state == IDLE) | (state == SHIFT & cnt == 0 & m_ready_i).
  - The m_ready_i term allows back-to-back vectors with no bubble.
  - No combinational path from s_valid_i to m_*.
- End of vector (output transfer with cnt == 0):
  - If an input transfer occurs in the same cycle: reload vec, lst and cnt = Depth-1; stay in SHIFT.
  - Otherwise: go to IDLE, m_valid_o = 0.
- Latency: first word valid 1 cycle after the input transfer.
- Throughput: 1 word/cycle sustained with m_ready_i held high.
- Depth == 1:
  - cnt stays 0; each vector is a single word.
  - Behaves as a one-entry full-throughput register slice; m_last_o = lst.
- Stall:
  - m_ready_i low holds vec, cnt and all outputs unchanged.
  - s_ready_o stays 0 while in SHIFT.
- Reset mid-operation: asserting rst_n_i drops m_valid_o immediately (asynchronous). The pending vector is discarded.

Optional Feature:
- Macro: STREAM_SERIALIZER_FLUSH_EN.
- When defined, adds input port flush_i (1 bit, synchronous, active-high).
- When flush_i = 1:
  - next state IDLE, cnt = 0, m_valid_o = 0 the following cycle.
  - any pending vector is dropped.
  - flush_i has priority over a same-cycle input transfer; that vector is also dropped, and s_ready_o is forced 0 in that cycle.
- When undefined: no flush_i port; logic identical to the above with flush tied off.

Test Plan:
- Depth=4, Width=16, m_ready_i=1; send vector {0x0004,0x0003,0x0002,0x0001} with s_last_i=1 -> m_data_o 0x0004,0x0003,0x0002,0x0001 on consecutive cycles starting 1 cycle after the transfer; m_last_o=1 only on 0x0001.
- Three vectors back-to-back with s_valid_i held high, m_ready_i=1 -> 12 consecutive valid words, no bubble; s_ready_o pulses exactly on each cnt==0 cycle.
- Random m_ready_i (50%) -> output word sequence equals input slices Depth-1..0 in order; m_data_o stable across every stall cycle.
- Depth=1: vectors 0xAAAA then 0x5555, m_ready_i toggling -> pure register-slice behaviour; no loss or duplication.
- Assert rst_n_i low while cnt=2 -> m_valid_o=0 immediately; after release s_ready_o=1 and the next vector emits from its slice 3.
- With STREAM_SERIALIZER_FLUSH_EN: flush_i at cnt=1 -> m_valid_o=0 next cycle, the remaining word never appears, and the next vector emits normally.

Source files
------------

// File: rtl/stream_serializer.sv
// Parallel-in, serial-out converter: one Depth-word vector in, Depth words out, slice Depth-1 first.
// Define STREAM_SERIALIZER_FLUSH_EN to add a synchronous, active-high flush_i input.
module stream_serializer #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
`ifdef STREAM_SERIALIZER_FLUSH_EN
    input  logic                   flush_i,
`endif
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [Width*Depth-1:0] s_data_i,
    input  logic                   s_last_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [Width-1:0]       m_data_o,
    output logic                   m_last_o
);

    localparam int              CntW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(Depth - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e                 state_q, state_d;
    logic [Width*Depth-1:0] vec_q, vec_d;
    logic                   lst_q, lst_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [Width-1:0]       data_q, data_d;
    logic                   flush;
    logic                   cnt_zero;
    logic                   in_xfer;
    logic                   out_xfer;

`ifdef STREAM_SERIALIZER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign cnt_zero  = (cnt_q == '0);
    assign m_valid_o = (state_q == SHIFT);
    assign m_data_o  = data_q;
    assign m_last_o  = m_valid_o & lst_q & cnt_zero;
    // A new vector may enter in the same cycle the final word of the current one leaves.
    assign s_ready_o = ~flush & ((state_q == IDLE) | (m_valid_o & cnt_zero & m_ready_i));
    assign in_xfer   = s_valid_i & s_ready_o;
    assign out_xfer  = m_valid_o & m_ready_i;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        vec_d   = vec_q;
        lst_d   = lst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (in_xfer) begin
            state_d = SHIFT;
            vec_d   = s_data_i;
            lst_d   = s_last_i;
            cnt_d   = LastIdx;
            data_d  = s_data_i[(Depth-1)*Width +: Width];
        end else if (out_xfer) begin
            if (cnt_zero) begin
                state_d = IDLE;
            end else begin
                cnt_d  = cnt_q - 1'b1;
                data_d = vec_q[int'(cnt_d)*Width +: Width];
            end
        end
    end

    // NOTE: control and output registers take non-blocking updates under the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // NOTE: the hold register is deliberately not reset; m_valid_o and m_last_o gate its contents.
    always_ff @(posedge clk_i) begin
        vec_q <= vec_d;
        lst_q <= lst_d;
    end

endmodule
